// File: rtl/tff_bank_arbiter_if.sv
// Requester-side bus of the shared T flip-flop bank: flattened per-requester
// request/mask/count inputs and the granted bank state.
interface tff_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int CW    = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] mask_in;
    logic [NREQ*CW-1:0]    cnt_in;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      qb;

    modport master (output req, mask_in, cnt_in, input gnt, busy, done, q, qb);
    modport slave  (input req, mask_in, cnt_in, output gnt, busy, done, q, qb);
endinterface

// File: rtl/tff_bank_arbiter.sv
// Round-robin shared T flip-flop bank: one granted requester toggles the bank
// with its latched mask for its latched number of cycles, then releases it.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= q ^ t;
    end
endmodule

module tff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int CW    = 4
) (
    input logic               clk,
    input logic               rst,
    tff_bank_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state, state_nxt;
    logic [IW-1:0]              ptr, idx, sel, cand;
    logic                       found;
    logic [WIDTH-1:0]           mask;
    logic [CW-1:0]              cnt;
    logic [NREQ-1:0][WIDTH-1:0] mask_arr;
    logic [NREQ-1:0][CW-1:0]    cnt_arr;
    logic                       toggle, abort;
    logic [WIDTH-1:0]           t_vec, q;

    assign mask_arr = bus.mask_in;
    assign cnt_arr  = bus.cnt_in;

    function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
        return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // First set request scanning from ptr upward, wrapping mod NREQ
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // A dropped request aborts on the same edge, so that edge must not toggle
    assign abort  = (state == RUN) && !bus.req[idx];
    assign toggle = (state == RUN) &&  bus.req[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            idx   <= '0;
            mask  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (found) begin
                    idx  <= sel;
                    mask <= mask_arr[sel];
                    cnt  <= cnt_arr[sel];
                end
                RUN: begin
                    if (toggle) cnt <= cnt - 1'b1;
                    else        ptr <= inc_idx(idx);
                end
                DONE:    ptr <= inc_idx(idx);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (found) state_nxt = (cnt_arr[sel] != '0) ? RUN : DONE;
            RUN: begin
                if (abort)                 state_nxt = IDLE;
                else if (cnt == CW'(1))    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
        bus.gnt  = '0;
        if (state != IDLE) bus.gnt[idx] = 1'b1;
    end

    assign t_vec = toggle ? mask : '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[i]),
            .q   (q[i])
        );
    end

    assign bus.q  = q;
    assign bus.qb = ~q;
endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Directed checks of the shared T flip-flop bank arbiter; drives on negedge, samples on negedge.
module tb_tff_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tff_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CW(CW)) bus ();

    tff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset;
        rst         = 1'b1;
        bus.req     = '0;
        bus.mask_in = '0;
        bus.cnt_in  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL reset_q got %b want 0000", bus.q); end
        checks++; if (bus.qb !== 4'b1111) begin errors++; $display("FAIL reset_qb got %b want 1111", bus.qb); end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    endtask

    task automatic test_single;
        logic [3:0] expq [0:2];
        expq[0] = 4'b0101; expq[1] = 4'b0000; expq[2] = 4'b0101;
        apply_reset();
        bus.mask_in[3:0] = 4'b0101;
        bus.cnt_in[3:0]  = 4'd3;
        bus.req          = 4'b0001;
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b want 0001", bus.gnt); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", bus.busy); end
        checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL single_q0 got %b want 0000", bus.q); end
        // mask/count changes after the grant must not reach the running transaction
        bus.mask_in[3:0] = 4'b1111;
        bus.cnt_in[3:0]  = 4'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.q !== expq[i]) begin errors++; $display("FAIL single_q step %0d got %b want %b", i, bus.q, expq[i]); end
            checks++; if (bus.done !== (i == 2)) begin errors++; $display("FAIL single_done step %0d got %b want %b", i, bus.done, (i == 2)); end
        end
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt_done got %b want 0001", bus.gnt); end
        checks++; if (bus.qb !== 4'b1010) begin errors++; $display("FAIL single_qb got %b want 1010", bus.qb); end
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_release_gnt got %b want 0000", bus.gnt); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL single_release_done got %b want 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_release_busy got %b want 0", bus.busy); end
        checks++; if (bus.q !== 4'b0101) begin errors++; $display("FAIL single_release_q got %b want 0101", bus.q); end
    endtask

    task automatic test_round_robin;
        logic [3:0] one;
        logic [3:0] exp_g;
        int         dones;
        one   = 4'b0001;
        dones = 0;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            bus.mask_in[i*WIDTH +: WIDTH] = 4'b0001;
            bus.cnt_in[i*CW +: CW]        = 4'd1;
        end
        bus.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_g = one << (t % 4);
            tick();
            checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL rr_gnt %0d got %b want %b", t, bus.gnt, exp_g); end
            if (bus.done === 1'b1) dones++;
            tick();
            checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL rr_gnt_done %0d got %b want %b", t, bus.gnt, exp_g); end
            if (bus.done === 1'b1) dones++;
            tick();
            checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rr_idle_gnt %0d got %b want 0000", t, bus.gnt); end
            if (bus.done === 1'b1) dones++;
        end
        bus.req = 4'b0000;
        checks++; if (dones !== 5) begin errors++; $display("FAIL rr_done_count got %0d want 5", dones); end
        checks++; if (bus.q !== 4'b0001) begin errors++; $display("FAIL rr_q got %b want 0001", bus.q); end
    endtask

    task automatic test_zero_count;
        apply_reset();
        bus.mask_in[2*WIDTH +: WIDTH] = 4'b1111;
        bus.cnt_in[2*CW +: CW]        = 4'd0;
        bus.req                       = 4'b0100;
        tick();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL zero_gnt got %b want 0100", bus.gnt); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", bus.done); end
        checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL zero_q got %b want 0000", bus.q); end
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL zero_release_gnt got %b want 0000", bus.gnt); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_release_done got %b want 0", bus.done); end
    endtask

    task automatic test_abort;
        int dones;
        dones = 0;
        apply_reset();
        bus.mask_in[1*WIDTH +: WIDTH] = 4'b1111;
        bus.cnt_in[1*CW +: CW]        = 4'd8;
        bus.req                       = 4'b0010;
        tick();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL abort_gnt got %b want 0010", bus.gnt); end
        tick();
        checks++; if (bus.q !== 4'b1111) begin errors++; $display("FAIL abort_q1 got %b want 1111", bus.q); end
        if (bus.done === 1'b1) dones++;
        tick();
        checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL abort_q2 got %b want 0000", bus.q); end
        if (bus.done === 1'b1) dones++;
        bus.req = 4'b0000;
        tick();
        if (bus.done === 1'b1) dones++;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL abort_idle_gnt got %b want 0000", bus.gnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got %b want 0", bus.busy); end
        checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL abort_hold_q got %b want 0000", bus.q); end
        checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", dones); end
        for (int i = 0; i < NREQ; i++) bus.cnt_in[i*CW +: CW] = 4'd1;
        bus.req = 4'b1111;
        tick();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL abort_next_gnt got %b want 0100", bus.gnt); end
        bus.req = 4'b0000;
    endtask

    task automatic test_mid_reset;
        apply_reset();
        // finish requester 1 so the pointer sits at 2 before the reset
        bus.cnt_in[1*CW +: CW] = 4'd0;
        bus.req                = 4'b0010;
        tick();
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL midrst_pre_gnt got %b want 0000", bus.gnt); end
        bus.mask_in[2*WIDTH +: WIDTH] = 4'b0011;
        bus.cnt_in[2*CW +: CW]        = 4'd10;
        bus.req                       = 4'b0100;
        tick();
        tick();
        tick();
        tick();
        checks++; if (bus.q !== 4'b0011) begin errors++; $display("FAIL midrst_run_q got %b want 0011", bus.q); end
        rst = 1'b1;
        tick();
        checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL midrst_q got %b want 0000", bus.q); end
        checks++; if (bus.qb !== 4'b1111) begin errors++; $display("FAIL midrst_qb got %b want 1111", bus.qb); end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL midrst_gnt got %b want 0000", bus.gnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus.done); end
        rst     = 1'b0;
        bus.req = 4'b1111;
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL midrst_first_gnt got %b want 0001", bus.gnt); end
        bus.req = 4'b0000;
    endtask

    initial begin
        rst         = 1'b1;
        bus.req     = '0;
        bus.mask_in = '0;
        bus.cnt_in  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_count();
        test_abort();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
